// File: rtl/wb_rr_xbar.sv
// Wishbone N x M crossbar with an independent registered round-robin arbiter per slave.
// Each master's slave index is latched at grant, and responses are routed back only to that owner.
module wb_rr_xbar #(
  parameter int N_MASTER  = 2,
  parameter int N_SLAVE   = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SLV_SEL_W = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_MASTER-1:0]            m_cyc_i,
  input  logic [N_MASTER-1:0]            m_stb_i,
  input  logic [N_MASTER-1:0]            m_we_i,
  input  logic [N_MASTER*ADDR_W-1:0]     m_adr_i,
  input  logic [N_MASTER*DATA_W-1:0]     m_dat_i,
  input  logic [N_MASTER*DATA_W/8-1:0]   m_sel_i,
  output logic [N_MASTER*DATA_W-1:0]     m_dat_o,
  output logic [N_MASTER-1:0]            m_ack_o,
  output logic [N_MASTER-1:0]            m_err_o,
  output logic [N_MASTER-1:0]            m_rty_o,
  output logic [N_MASTER-1:0]            m_gnt_o,
  output logic [N_SLAVE-1:0]             s_cyc_o,
  output logic [N_SLAVE-1:0]             s_stb_o,
  output logic [N_SLAVE-1:0]             s_we_o,
  output logic [N_SLAVE*ADDR_W-1:0]      s_adr_o,
  output logic [N_SLAVE*DATA_W-1:0]      s_dat_o,
  output logic [N_SLAVE*DATA_W/8-1:0]    s_sel_o,
  input  logic [N_SLAVE*DATA_W-1:0]      s_dat_i,
  input  logic [N_SLAVE-1:0]             s_ack_i,
  input  logic [N_SLAVE-1:0]             s_err_i,
  input  logic [N_SLAVE-1:0]             s_rty_i
);

  localparam int BSEL_W = DATA_W / 8;
  localparam int PTR_W  = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int LOW_W  = ADDR_W - SLV_SEL_W;

  logic [N_SLAVE-1:0][N_MASTER-1:0] r_owner;
  logic [N_SLAVE-1:0][PTR_W-1:0]    r_ptr;
  logic [N_MASTER-1:0]              r_derr;

  logic [SLV_SEL_W-1:0]             w_sel [N_MASTER];
  logic [N_MASTER-1:0]              w_owns;
  logic [N_MASTER-1:0]              w_unmapped;
  logic [N_SLAVE-1:0][N_MASTER-1:0] w_req;
  logic [N_SLAVE-1:0]               w_free;
  logic [N_SLAVE-1:0][N_MASTER-1:0] w_win;
  logic [N_SLAVE-1:0][PTR_W-1:0]    w_next_ptr;
  logic [N_MASTER-1:0][N_SLAVE-1:0] w_owner_col;
  logic                             w_found;
  int                               w_idx;

  // Address decode and request generation; a master already holding a slave never requests another.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_owns      = '0;
    w_unmapped  = '0;
    w_req       = '0;
    w_owner_col = '0;
    for (int s = 0; s < N_SLAVE; s++) begin
      w_owns = w_owns | r_owner[s];
      for (int i = 0; i < N_MASTER; i++) begin
        w_owner_col[i][s] = r_owner[s][i];
      end
    end
    for (int i = 0; i < N_MASTER; i++) begin
      w_sel[i]      = m_adr_i[i*ADDR_W + LOW_W +: SLV_SEL_W];
      w_unmapped[i] = (int'(w_sel[i]) >= N_SLAVE);
      for (int s = 0; s < N_SLAVE; s++) begin
        w_req[s][i] = m_cyc_i[i] & (int'(w_sel[i]) == s) & ~w_owns[i];
      end
    end
  end

  // Round-robin pick per slave: first requester at or above the pointer, wrapping.
  always_comb begin
    w_free     = '0;
    w_win      = '0;
    w_next_ptr = r_ptr;
    w_found    = 1'b0;
    w_idx      = 0;
    for (int s = 0; s < N_SLAVE; s++) begin
      w_free[s] = ~|(r_owner[s] & m_cyc_i);
      w_found   = 1'b0;
      for (int k = 0; k < N_MASTER; k++) begin
        w_idx = int'(r_ptr[s]) + k;
        if (w_idx >= N_MASTER) w_idx = w_idx - N_MASTER;
        for (int j = 0; j < N_MASTER; j++) begin
          if (!w_found && (j == w_idx) && w_req[s][j]) begin
            w_win[s][j]   = 1'b1;
            w_next_ptr[s] = (j == N_MASTER - 1) ? '0 : PTR_W'(j + 1);
            w_found       = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_owner <= '0;
      r_ptr   <= '0;
      r_derr  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every slave sees the same pre-edge values.
      for (int s = 0; s < N_SLAVE; s++) begin
        if (w_free[s]) begin
          r_owner[s] <= w_win[s];
          if (|w_win[s]) r_ptr[s] <= w_next_ptr[s];
        end
      end
      // Self-clearing so an unmapped strobe yields a one-cycle error pulse.
      r_derr <= m_cyc_i & m_stb_i & w_unmapped & ~w_owns & ~r_derr;
    end
  end

  // Slave side: driven from the owning master, address select field zeroed.
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    s_we_o  = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    for (int s = 0; s < N_SLAVE; s++) begin
      for (int i = 0; i < N_MASTER; i++) begin
        if (r_owner[s][i]) begin
          s_cyc_o[s]                     = m_cyc_i[i];
          s_stb_o[s]                     = m_stb_i[i];
          s_we_o[s]                      = m_we_i[i];
          s_adr_o[s*ADDR_W +: ADDR_W]    = {{SLV_SEL_W{1'b0}}, m_adr_i[i*ADDR_W +: LOW_W]};
          s_dat_o[s*DATA_W +: DATA_W]    = m_dat_i[i*DATA_W +: DATA_W];
          s_sel_o[s*BSEL_W +: BSEL_W]    = m_sel_i[i*BSEL_W +: BSEL_W];
        end
      end
    end
  end

  // Master side: responses only from the slave this master owns, plus the decode error.
  always_comb begin
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = r_derr;
    m_rty_o = '0;
    m_gnt_o = w_owns;
    for (int i = 0; i < N_MASTER; i++) begin
      for (int s = 0; s < N_SLAVE; s++) begin
        if (r_owner[s][i]) begin
          m_dat_o[i*DATA_W +: DATA_W] = s_dat_i[s*DATA_W +: DATA_W];
          m_ack_o[i]                  = s_ack_i[s];
          m_err_o[i]                  = s_err_i[s] | r_derr[i];
          m_rty_o[i]                  = s_rty_i[s];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int s = 0; s < N_SLAVE; s++) begin
        assert ($onehot0(r_owner[s]));
      end
      for (int i = 0; i < N_MASTER; i++) begin
        assert ($onehot0(w_owner_col[i]));
      end
    end
  end

endmodule

// File: tb/tb_wb_rr_xbar.sv
// Directed self-checking bench for wb_rr_xbar (2 masters, 4 slaves) with a simple acking slave model.
module tb_wb_rr_xbar;

  localparam int NM = 2;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [NM-1:0]     m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
  logic [NM*AW-1:0]  m_adr_i = '0;
  logic [NM*DW-1:0]  m_dat_i = '0;
  logic [NM*BW-1:0]  m_sel_i = '1;
  logic [NM*DW-1:0]  m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o, m_gnt_o;
  logic [NS-1:0]     s_cyc_o, s_stb_o, s_we_o;
  logic [NS*AW-1:0]  s_adr_o;
  logic [NS*DW-1:0]  s_dat_o;
  logic [NS*BW-1:0]  s_sel_o;
  logic [NS*DW-1:0]  s_dat_i;
  logic [NS-1:0]     s_ack_i, s_err_i, s_rty_i;
  logic [NS-1:0]     ack_en = '1;

  int n_checks = 0;
  int n_errors = 0;

  wb_rr_xbar #(.N_MASTER(NM), .N_SLAVE(NS), .ADDR_W(AW), .DATA_W(DW), .SLV_SEL_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
    .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_gnt_o(m_gnt_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  always #5 clk_i = ~clk_i;

  // Slave s returns 0xD000_000s and acks while strobed, gated by ack_en.
  always_comb begin
    s_err_i = '0;
    s_rty_i = '0;
    for (int s = 0; s < NS; s++) begin
      s_ack_i[s]           = s_cyc_o[s] & s_stb_o[s] & ack_en[s];
      s_dat_i[s*DW +: DW]  = 32'hD000_0000 | 32'(s);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int i, input logic cyc, input logic [31:0] adr);
    m_cyc_i[i]          = cyc;
    m_stb_i[i]          = cyc;
    m_adr_i[i*AW +: AW] = adr;
    m_dat_i[i*DW +: DW] = 32'h5A00_0000 | 32'(i);
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    check("rst_gnt",   32'(m_gnt_o), 32'h0);
    step(); step();
    rst_i = 1'b0;
    step();

    // Parallel access to s0 and s1
    drive(0, 1'b1, 32'h0000_0010);
    drive(1, 1'b1, 32'h1000_0020);
    check("par_latency", 32'(s_cyc_o), 32'h0);
    step();
    check("par_s_cyc",  32'(s_cyc_o), 32'h3);
    check("par_gnt",    32'(m_gnt_o), 32'h3);
    check("par_ack",    32'(m_ack_o), 32'h3);
    check("par_m0_dat", m_dat_o[0*DW +: DW], 32'hD000_0000);
    check("par_m1_dat", m_dat_o[1*DW +: DW], 32'hD000_0001);
    check("par_s0_adr", s_adr_o[0*AW +: AW], 32'h0000_0010);
    check("par_s1_adr", s_adr_o[1*AW +: AW], 32'h0000_0020);
    drive(0, 1'b0, 32'h0); drive(1, 1'b0, 32'h0);
    check("par_drop_s_cyc", 32'(s_cyc_o), 32'h0);
    step();
    check("par_release", 32'(m_gnt_o), 32'h0);

    // Contention on slave 2
    drive(0, 1'b1, 32'h2000_0000);
    drive(1, 1'b1, 32'h2000_0000);
    step();
    check("cont_gnt_m0", 32'(m_gnt_o), 32'h1);
    check("cont_s_cyc",  32'(s_cyc_o), 32'h4);
    check("cont_ack_m0", 32'(m_ack_o), 32'h1);
    drive(0, 1'b0, 32'h0);
    step();
    check("cont_gnt_m1", 32'(m_gnt_o), 32'h2);
    drive(0, 1'b1, 32'h2000_0000);
    check("cont_ack_m1_only", 32'(m_ack_o), 32'h2);
    drive(1, 1'b0, 32'h0);
    step();
    check("cont_gnt_m0_again", 32'(m_gnt_o), 32'h1);
    drive(0, 1'b0, 32'h0);
    step();
    check("cont_idle", 32'(m_gnt_o), 32'h0);
    drive(0, 1'b1, 32'h2000_0000);
    drive(1, 1'b1, 32'h2000_0000);
    step();
    check("cont_rr_m1", 32'(m_gnt_o), 32'h2);
    drive(0, 1'b0, 32'h0); drive(1, 1'b0, 32'h0);
    step();

    // Late ack on slave 1 while M1 waits
    ack_en[1] = 1'b0;
    drive(0, 1'b1, 32'h1000_0000);
    drive(1, 1'b1, 32'h1000_0004);
    step();
    check("late_gnt",   32'(m_gnt_o), 32'h1);
    check("late_noack", 32'(m_ack_o), 32'h0);
    step(); step();
    ack_en[1] = 1'b1;
    #1;
    check("late_ack_m0",  32'(m_ack_o), 32'h1);
    check("late_m0_dat",  m_dat_o[0*DW +: DW], 32'hD000_0001);
    check("late_m1_dat",  m_dat_o[1*DW +: DW], 32'h0);
    drive(0, 1'b0, 32'h0);
    check("late_m1_wait", 32'(m_ack_o), 32'h0);
    step();
    check("late_m1_gnt", 32'(m_gnt_o), 32'h2);
    check("late_m1_ack", 32'(m_ack_o), 32'h2);
    drive(1, 1'b0, 32'h0);
    step();

    // Unmapped address
    drive(0, 1'b1, 32'hF000_0000);
    check("unm_err_n",   32'(m_err_o), 32'h0);
    step();
    check("unm_err_n1",  32'(m_err_o), 32'h1);
    check("unm_s_cyc1",  32'(s_cyc_o), 32'h0);
    check("unm_gnt",     32'(m_gnt_o), 32'h0);
    drive(0, 1'b0, 32'h0);
    step();
    check("unm_err_n2",  32'(m_err_o), 32'h0);
    check("unm_s_cyc2",  32'(s_cyc_o), 32'h0);

    // Select change mid-cycle
    drive(0, 1'b1, 32'h1000_0008);
    step();
    check("selc_s_cyc", 32'(s_cyc_o), 32'h2);
    drive(0, 1'b1, 32'h3000_0004);
    check("selc_s_cyc_live", 32'(s_cyc_o), 32'h2);
    check("selc_s1_adr", s_adr_o[1*AW +: AW], 32'h0000_0004);
    check("selc_s3_adr", s_adr_o[3*AW +: AW], 32'h0);
    step();
    check("selc_hold", 32'(s_cyc_o), 32'h2);
    check("selc_gnt",  32'(m_gnt_o), 32'h1);
    drive(0, 1'b0, 32'h0);
    step();

    // Reset mid-transfer, then rearbitration from pointer 0
    drive(0, 1'b1, 32'h0000_0000);
    step();
    check("rmid_s_cyc", 32'(s_cyc_o), 32'h1);
    check("rmid_ack",   32'(m_ack_o), 32'h1);
    rst_i = 1'b1;
    drive(1, 1'b1, 32'h0000_0040);
    check("rmid_async_s_cyc", 32'(s_cyc_o), 32'h0);
    check("rmid_async_gnt",   32'(m_gnt_o), 32'h0);
    check("rmid_async_ack",   32'(m_ack_o), 32'h0);
    rst_i = 1'b0;
    #1;
    step();
    check("rmid_rearb_gnt", 32'(m_gnt_o), 32'h1);
    check("rmid_rearb_cyc", 32'(s_cyc_o), 32'h1);
    check("rmid_rearb_adr", s_adr_o[0*AW +: AW], 32'h0);
    drive(0, 1'b0, 32'h0); drive(1, 1'b0, 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
